// File: rtl/mem_wb_skid_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_skid_reg
//
// Purpose
//    MEM->WB pipeline register with a valid/ready handshake and a 2-entry skid
//    buffer. It sits between the data-memory stage and register write-back.
//    It provides back-pressure, flush and a registered destination field.
//    Register-file write enables are qualified by out_valid and by ~PROHIB.
//    As a result, a bubble or a prohibited operation never causes a write.
//
// Parameters
//    DATA_W   width of the memory word (Do) and of the ALU result
//    BYTE_W   width of the byte-read path (Dob)
//    RG_W     destination register index width
//
// Ports
//    clk, rst_n          rising-edge clock, asynchronous active-low reset
//    flush               synchronous squash of every held entry (highest priority)
//    in_valid/in_ready   upstream handshake; in_ready is a pure register decode
//    Do_In .. PROHIB_In  entry fields presented by the MEM stage
//    out_valid/out_ready downstream handshake
//    Do .. SEL_DAT       head-entry fields, driven 0 while the head is invalid
//    WE_C, WE_V          head write enables & out_valid & ~PROHIB
//    PROHIB_WB           head PROHIB & out_valid
//
// Configuration
//    MEM_WB_FWD_EN  when defined, adds the forwarding outputs fwd_valid,
//                   fwd_rg and fwd_data, which feed the hazard unit. When the
//                   macro is undefined, these ports and their logic are absent.
// -----------------------------------------------------------------------------
module mem_wb_skid_reg #(
   parameter int DATA_W = 32,
   parameter int BYTE_W = 8,
   parameter int RG_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   // upstream (MEM stage)
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] Do_In,
   input  logic [BYTE_W-1:0] Dob_In,
   input  logic [DATA_W-1:0] ALU_In,
   input  logic [RG_W-1:0]   Rg_In,
   input  logic              WE_C_In,
   input  logic              WE_V_In,
   input  logic              SEL_C_In,
   input  logic              SEL_DAT_In,
   input  logic              PROHIB_In,
   // downstream (WB stage)
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] Do,
   output logic [BYTE_W-1:0] Dob,
   output logic [DATA_W-1:0] ALU_Result,
   output logic [RG_W-1:0]   Rg,
   output logic              SEL_C,
   output logic              SEL_DAT,
   output logic              WE_C,
   output logic              WE_V,
   output logic              PROHIB_WB
`ifdef MEM_WB_FWD_EN
   ,
   output logic              fwd_valid,
   output logic [RG_W-1:0]   fwd_rg,
   output logic [DATA_W-1:0] fwd_data
`endif
);

   // One entry packed into a flat vector so that head and skid move as a unit.
   localparam int PW = 2*DATA_W + BYTE_W + RG_W + 5;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t          r_state;
   logic            r_in_ready;
   logic            r_out_valid;
   logic [PW-1:0]   r_head;
   logic [PW-1:0]   r_skid;

   logic [PW-1:0]   w_in_pld;
   logic [PW-1:0]   w_head_masked;
   logic            w_acc;
   logic            w_pop;

   logic [DATA_W-1:0] w_do;
   logic [BYTE_W-1:0] w_dob;
   logic [DATA_W-1:0] w_alu;
   logic [RG_W-1:0]   w_rg;
   logic              w_we_c;
   logic              w_we_v;
   logic              w_sel_c;
   logic              w_sel_dat;
   logic              w_prohib;

   assign w_in_pld = {Do_In, Dob_In, ALU_In, Rg_In,
                      WE_C_In, WE_V_In, SEL_C_In, SEL_DAT_In, PROHIB_In};

   assign w_acc = in_valid & r_in_ready;
   assign w_pop = r_out_valid & out_ready;

   // ---------------------------------------------------------------------------
   // Control and storage. in_ready and out_valid are kept as registers that are
   // updated together with the state. This keeps in_ready free of any
   // combinational path from out_ready.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_head      <= '0;
         r_skid      <= '0;
      end else if (flush) begin
         // Stale payload may remain in the flops. Outputs are masked by
         // out_valid, so that payload is never visible.
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_acc) begin
                  r_head      <= w_in_pld;
                  r_state     <= ST_ONE;
                  r_out_valid <= 1'b1;
                  r_in_ready  <= 1'b1;
               end
            end
            ST_ONE: begin
               if (w_acc && !w_pop) begin
                  // Head is stalled, so the newcomer parks in the skid slot.
                  r_skid      <= w_in_pld;
                  r_state     <= ST_FULL;
                  r_in_ready  <= 1'b0;
               end else if (w_acc && w_pop) begin
                  r_head      <= w_in_pld;
               end else if (w_pop) begin
                  r_state     <= ST_EMPTY;
                  r_out_valid <= 1'b0;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so no accept can coincide with the pop.
               if (w_pop) begin
                  r_head      <= r_skid;
                  r_state     <= ST_ONE;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_EMPTY;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Output decode. Masking with out_valid forces every field to 0 while the
   // head is invalid. This masking applies during reset, when empty and after
   // a flush, so the outputs clear immediately on an asynchronous reset.
   // ---------------------------------------------------------------------------
   assign w_head_masked = r_head & {PW{r_out_valid}};

   assign {w_do, w_dob, w_alu, w_rg,
           w_we_c, w_we_v, w_sel_c, w_sel_dat, w_prohib} = w_head_masked;

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign Do         = w_do;
   assign Dob        = w_dob;
   assign ALU_Result = w_alu;
   assign Rg         = w_rg;
   assign SEL_C      = w_sel_c;
   assign SEL_DAT    = w_sel_dat;
   // Valid is already folded in through the mask; PROHIB vetoes any write.
   assign WE_C       = w_we_c & ~w_prohib;
   assign WE_V       = w_we_v & ~w_prohib;
   assign PROHIB_WB  = w_prohib;

`ifdef MEM_WB_FWD_EN
   assign fwd_valid  = (w_we_c | w_we_v) & ~w_prohib;
   assign fwd_rg     = w_rg;
   assign fwd_data   = w_sel_dat ? w_do : w_alu;
`endif

endmodule
